// File: rtl/isa_io_target.sv
// ISA I/O-space target: 16-byte window at BASE_ADDR.
// Host writes queue into a FIFO; host reads return a local register file.
module isa_io_target #(
    parameter logic [15:0] BASE_ADDR   = 16'h0220,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   isa_addr,
    input  logic [15:0]                   isa_data_in,
    output logic [15:0]                   isa_data_out,
    output logic                          isa_data_oe,
    input  logic                          isa_iow_n,
    input  logic                          isa_ior_n,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [3:0]                    wr_addr,
    output logic [7:0]                    wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   wr_count,
    input  logic                          rf_we,
    input  logic [3:0]                    rf_addr,
    input  logic [7:0]                    rf_wdata,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    logic [SYNC_STAGES-1:0] iow_sr, ior_sr, primed_sr;
    logic [15:0]            addr_sr [SYNC_STAGES];
    logic [7:0]             data_sr [SYNC_STAGES];

    logic        sync_iow_n, sync_ior_n, primed, hit;
    logic [15:0] sync_addr;
    logic [7:0]  sync_data;
    logic        unused_data_hi;

    logic [1:0]  state;
    logic        armed_w, armed_r;
    logic [3:0]  hold_addr;
    logic [7:0]  hold_data;
    logic [7:0]  dout;
    logic        go_write, go_read, push_req, push_ok, pop;

    logic [7:0]  rf  [16];
    logic [11:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    assign sync_iow_n     = iow_sr[SYNC_STAGES-1];
    assign sync_ior_n     = ior_sr[SYNC_STAGES-1];
    assign sync_addr      = addr_sr[SYNC_STAGES-1];
    assign sync_data      = data_sr[SYNC_STAGES-1];
    assign primed         = &primed_sr;
    assign hit            = (sync_addr[15:4] == BASE_ADDR[15:4]);
    assign unused_data_hi = ^isa_data_in[15:8];

    // A strobe only fires after it was seen high on a fully flushed
    // synchronizer, so a strobe held across reset is ignored.
    assign go_write = (state == S_IDLE) && armed_w && hit
                      && !sync_iow_n && sync_ior_n;
    assign go_read  = (state == S_IDLE) && armed_r && hit
                      && !sync_ior_n && sync_iow_n;
    assign push_req = (state == S_WRITE) && sync_iow_n;
    assign pop      = (count != '0) && wr_ready;
    assign push_ok  = push_req && ((count != FULL) || pop);

    // Synchronize the asynchronous ISA bus into clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iow_sr    <= '1;
            ior_sr    <= '1;
            primed_sr <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                addr_sr[i] <= '0;
                data_sr[i] <= '0;
            end
        end else begin
            iow_sr    <= {iow_sr[SYNC_STAGES-2:0], isa_iow_n};
            ior_sr    <= {ior_sr[SYNC_STAGES-2:0], isa_ior_n};
            primed_sr <= {primed_sr[SYNC_STAGES-2:0], 1'b1};
            addr_sr[0] <= isa_addr;
            data_sr[0] <= isa_data_in[7:0];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                addr_sr[i] <= addr_sr[i-1];
                data_sr[i] <= data_sr[i-1];
            end
        end
    end

    // Strobe FSM with re-arm tracking and registered read drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            armed_w   <= 1'b0;
            armed_r   <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            dout      <= '0;
            isa_data_oe <= 1'b0;
        end else begin
            if (!primed)         armed_w <= 1'b0;
            else if (sync_iow_n) armed_w <= 1'b1;
            else if (go_write)   armed_w <= 1'b0;
            if (!primed)         armed_r <= 1'b0;
            else if (sync_ior_n) armed_r <= 1'b1;
            else if (go_read)    armed_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_write) begin
                        state     <= S_WRITE;
                        hold_addr <= sync_addr[3:0];
                        hold_data <= sync_data;
                    end else if (go_read) begin
                        state       <= S_READ;
                        isa_data_oe <= 1'b1;
                        dout        <= rf[sync_addr[3:0]];
                    end
                end
                S_WRITE: begin
                    if (sync_iow_n) begin
                        state <= S_IDLE;
                    end else begin
                        hold_addr <= sync_addr[3:0];
                        hold_data <= sync_data;
                    end
                end
                S_READ: begin
                    if (sync_ior_n) begin
                        state       <= S_IDLE;
                        isa_data_oe <= 1'b0;
                        dout        <= '0;
                    end else begin
                        dout <= rf[sync_addr[3:0]];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Local logic loads the host-visible read registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (rf_we) begin
            rf[rf_addr] <= rf_wdata;
        end
    end

    // FIFO storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= {hold_addr, hold_data};
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push_req && !push_ok) ovf <= 1'b1;
            else if (ovf_clr)         ovf <= 1'b0;
        end
    end

    assign isa_data_out = {8'h00, dout};
    assign wr_valid     = (count != '0);
    assign wr_addr      = mem[rptr][11:8];
    assign wr_data      = mem[rptr][7:0];
    assign wr_count     = count;

endmodule

// File: tb/tb_isa_io_target.sv
// Directed bench for isa_io_target: writes, reads, misses,
// FIFO overflow and ordering, simultaneous pop, reset mid-read.
module tb_isa_io_target;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] isa_addr, isa_data_in, isa_data_out;
    logic        isa_data_oe, isa_iow_n, isa_ior_n;
    logic        wr_valid, wr_ready;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  wr_count;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wdata;
    logic        ovf, ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    isa_io_target dut (
        .clk(clk), .reset(reset),
        .isa_addr(isa_addr), .isa_data_in(isa_data_in),
        .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe),
        .isa_iow_n(isa_iow_n), .isa_ior_n(isa_ior_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_count(wr_count),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #10 clk = ~clk;

    // IOW# cycle of 15 clk (300 ns); optional wr_ready pulse on the
    // FSM exit cycle (third posedge after IOW# rises).
    task automatic isa_write(input logic [15:0] a, input logic [7:0] d,
                             input bit pulse);
        @(negedge clk);
        isa_addr    = a;
        isa_data_in = {8'hEE, d};
        repeat (2) @(negedge clk);
        isa_iow_n = 1'b0;
        repeat (15) @(negedge clk);
        isa_iow_n = 1'b1;
        repeat (2) @(negedge clk);
        if (pulse) wr_ready = 1'b1;
        @(negedge clk);
        if (pulse) wr_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic rf_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        rf_we = 1'b1; rf_addr = a; rf_wdata = d;
        @(negedge clk);
        rf_we = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (isa_data_oe !== 1'b0 || isa_data_out !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_oe: oe=%b d=%h want 0/0000",
                     isa_data_oe, isa_data_out);
        end
        n_cmp++;
        if (wr_valid !== 1'b0 || wr_count !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_fifo: valid=%b cnt=%0d want 0/0",
                     wr_valid, wr_count);
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovf: ovf=%b want 0", ovf);
        end
    endtask

    task automatic test_write;
        isa_write(16'h0223, 8'h5A, 1'b0);
        n_cmp++;
        if (wr_valid !== 1'b1 || wr_addr !== 4'h3 || wr_data !== 8'h5A
            || wr_count !== 4'd1) begin
            n_bad++;
            $display("FAIL write_head: v=%b a=%h d=%h c=%0d want 1/3/5a/1",
                     wr_valid, wr_addr, wr_data, wr_count);
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        n_cmp++;
        if (wr_count !== 4'd0 || wr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL write_pop: c=%0d v=%b want 0/0",
                     wr_count, wr_valid);
        end
    endtask

    task automatic test_read;
        int n;
        rf_write(4'd7, 8'hC3);
        @(negedge clk);
        isa_addr = 16'h0227;
        repeat (2) @(negedge clk);
        isa_ior_n = 1'b0;
        n = 0;
        while (isa_data_oe !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (isa_data_oe !== 1'b1 || n > 3) begin
            n_bad++;
            $display("FAIL read_oe_on: oe=%b after %0d clk want 1 by 3",
                     isa_data_oe, n);
        end
        n_cmp++;
        if (isa_data_out !== 16'h00C3) begin
            n_bad++;
            $display("FAIL read_data: got %h want 00c3", isa_data_out);
        end
        rf_write(4'd7, 8'h3C);
        @(negedge clk);
        n_cmp++;
        if (isa_data_out !== 16'h003C) begin
            n_bad++;
            $display("FAIL read_live: got %h want 003c", isa_data_out);
        end
        repeat (9) @(negedge clk);
        isa_ior_n = 1'b1;
        n = 0;
        while (isa_data_oe !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (isa_data_oe !== 1'b0 || n > 3 || isa_data_out !== 16'h0) begin
            n_bad++;
            $display("FAIL read_oe_off: oe=%b d=%h after %0d want 0/0000 by 3",
                     isa_data_oe, isa_data_out, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_miss;
        bit seen;
        isa_write(16'h0230, 8'h11, 1'b0);
        isa_write(16'h021F, 8'h22, 1'b0);
        n_cmp++;
        if (wr_count !== 4'd0 || wr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_write: c=%0d v=%b want 0/0",
                     wr_count, wr_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            isa_addr = (k == 0) ? 16'h0230 : 16'h021F;
            repeat (2) @(negedge clk);
            isa_ior_n = 1'b0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (j == 14) isa_ior_n = 1'b1;
                if (isa_data_oe !== 1'b0) seen = 1'b1;
            end
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL miss_read: oe asserted=1 want 0");
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++)
            isa_write(16'h0220 + 16'(i), 8'h10 + 8'(i), 1'b0);
        n_cmp++;
        if (wr_count !== 4'd8 || ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_full: c=%0d ovf=%b want 8/1", wr_count, ovf);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clr: ovf=%b want 0", ovf);
        end
        wr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_valid !== 1'b1 || wr_addr !== 4'(i)
                || wr_data !== 8'h10 + 8'(i)) begin
                n_bad++;
                $display("FAIL drain_%0d: v=%b a=%h d=%h want 1/%h/%h",
                         i, wr_valid, wr_addr, wr_data, 4'(i), 8'h10 + 8'(i));
            end
            @(negedge clk);
        end
        wr_ready = 1'b0;
        n_cmp++;
        if (wr_count !== 4'd0) begin
            n_bad++;
            $display("FAIL drain_empty: c=%0d want 0", wr_count);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++)
            isa_write(16'h0220 + 16'(i), 8'h40 + 8'(i), 1'b0);
        isa_write(16'h022F, 8'h99, 1'b1);
        n_cmp++;
        if (wr_count !== 4'd8 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pop_push: c=%0d ovf=%b want 8/0",
                     wr_count, ovf);
        end
        n_cmp++;
        if (wr_addr !== 4'h1 || wr_data !== 8'h41) begin
            n_bad++;
            $display("FAIL full_pop_head: a=%h d=%h want 1/41",
                     wr_addr, wr_data);
        end
        wr_ready = 1'b1;
        repeat (7) @(negedge clk);
        n_cmp++;
        if (wr_addr !== 4'hF || wr_data !== 8'h99 || wr_count !== 4'd1) begin
            n_bad++;
            $display("FAIL full_pop_tail: a=%h d=%h c=%0d want f/99/1",
                     wr_addr, wr_data, wr_count);
        end
        @(negedge clk);
        wr_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read;
        int  n;
        bit  seen;
        @(negedge clk);
        isa_addr = 16'h0227;
        repeat (2) @(negedge clk);
        isa_ior_n = 1'b0;
        n = 0;
        while (isa_data_oe !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (isa_data_oe !== 1'b1 || isa_data_out !== 16'h003C) begin
            n_bad++;
            $display("FAIL rst_pre_read: oe=%b d=%h want 1/003c",
                     isa_data_oe, isa_data_out);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (isa_data_oe !== 1'b0 || isa_data_out !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_async_oe: oe=%b d=%h want 0/0000",
                     isa_data_oe, isa_data_out);
        end
        @(negedge clk);
        reset = 1'b0;
        rf_write(4'd7, 8'hA5);
        seen = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (isa_data_oe !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL rst_held_ior: oe asserted=1 want 0");
        end
        isa_ior_n = 1'b1;
        repeat (4) @(negedge clk);
        isa_ior_n = 1'b0;
        n = 0;
        while (isa_data_oe !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (isa_data_oe !== 1'b1 || isa_data_out !== 16'h00A5) begin
            n_bad++;
            $display("FAIL rst_reread: oe=%b d=%h want 1/00a5",
                     isa_data_oe, isa_data_out);
        end
        isa_ior_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        isa_addr    = 16'h0000;
        isa_data_in = 16'h0000;
        isa_iow_n   = 1'b1;
        isa_ior_n   = 1'b1;
        wr_ready    = 1'b0;
        rf_we       = 1'b0;
        rf_addr     = 4'h0;
        rf_wdata    = 8'h00;
        ovf_clr     = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        test_write;
        test_read;
        test_miss;
        test_overflow;
        test_back_to_back;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
